// File: rtl/oflow_similarity_best_match.sv
// oflow_similarity_best_match
// Latches the current object's features, streams N previous-frame candidates
// through a 3-stage weighted-distance pipeline and reports the lowest-scoring
// candidate (score, id, arrival index) with a thresholded match and a done pulse.
module oflow_similarity_best_match #(
  parameter int COORD_W = 11,
  parameter int CH_W    = 8,
  parameter int DH_W    = 8,
  parameter int ID_W    = 12,
  parameter int WGT_W   = 8,
  parameter int SCORE_W = 32,
  parameter int CNT_W   = 7,
  localparam int FEAT_W = 4*COORD_W + 6*CH_W + DH_W + ID_W
) (
  input  logic               clk,
  input  logic               reset_N,
  input  logic               start,
  input  logic [FEAT_W-1:0]  cur_feat,
  input  logic [CNT_W-1:0]   num_cand,
  input  logic [7*WGT_W-1:0] weights,
  input  logic [SCORE_W-1:0] threshold,
  input  logic               cand_valid,
  input  logic [FEAT_W-1:0]  cand_feat,
  output logic               cand_ready,
  output logic               busy,
  output logic               done,
  output logic [SCORE_W-1:0] best_score,
  output logic [ID_W-1:0]    best_id,
  output logic [CNT_W-1:0]   best_index,
  output logic               match_found
);

  // Field offsets of {cm_x, cm_y, w, h, color1, color2, dh, id}
  localparam int DH_LO  = ID_W;
  localparam int C2_LO  = DH_LO + DH_W;
  localparam int C1_LO  = C2_LO + 3*CH_W;
  localparam int H_LO   = C1_LO + 3*CH_W;
  localparam int W_LO   = H_LO + COORD_W;
  localparam int Y_LO   = W_LO + COORD_W;
  localparam int X_LO   = Y_LO + COORD_W;
  localparam int COL_W  = CH_W + 2;
  localparam int DIFF_W = (COORD_W >= COL_W && COORD_W >= DH_W) ? COORD_W :
                          (COL_W >= DH_W) ? COL_W : DH_W;
  localparam int PROD_W = DIFF_W + WGT_W;
  localparam int ACC_W  = PROD_W + 3;
  localparam int EXT_W  = (ACC_W > SCORE_W) ? ACC_W : SCORE_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_q, state_d;

  logic [FEAT_W-1:ID_W]  cur_q;
  logic [CNT_W-1:0]      ncand_q;
  logic [7*WGT_W-1:0]    wgt_q;
  logic [SCORE_W-1:0]    thr_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  v1, v2, v3, v4;
  logic [DIFF_W-1:0]     s1_d [7];
  logic [PROD_W-1:0]     s2_p [7];
  logic [SCORE_W-1:0]    s3_score;
  logic [ID_W-1:0]       s1_id, s2_id, s3_id;
  logic [CNT_W-1:0]      s1_idx, s2_idx, s3_idx;

  logic [EXT_W-1:0]      sum_ext;
  logic [SCORE_W-1:0]    sum_sat;
  logic                  start_ok;
  logic                  accept;
  logic                  cur_id_unused;

  function automatic logic [COORD_W-1:0] abs_coord(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic logic [DH_W-1:0] abs_dh(input logic [DH_W-1:0] a,
                                             input logic [DH_W-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic logic [COL_W-1:0] sad_color(input logic [3*CH_W-1:0] a,
                                                 input logic [3*CH_W-1:0] b);
    logic [COL_W-1:0] acc;
    logic [CH_W-1:0]  ca, cb;
    acc = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      ca  = a[k*CH_W +: CH_W];
      cb  = b[k*CH_W +: CH_W];
      acc = acc + COL_W'((ca > cb) ? ca - cb : cb - ca);
    end
    return acc;
  endfunction

  // The current object's id plays no part in the distance.
  assign cur_id_unused = ^cur_feat[ID_W-1:0];

  assign start_ok = start && (state_q == IDLE);
  assign accept   = cand_valid && cand_ready;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  // Next-state and candidate handshake
  always_comb begin
    state_d    = state_q;
    cand_ready = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = (num_cand == '0) ? DONE : RUN;
      RUN: begin
        cand_ready = (cnt_q < ncand_q);
        if (cnt_q == ncand_q) state_d = DRAIN;
      end
      // v4 marks that the last best-update has landed in the result registers
      DRAIN: if (!(v1 || v2 || v3 || v4)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Seven-way sum of the weighted differences, saturated to SCORE_W
  always_comb begin
    sum_ext = '0;
    for (int unsigned i = 0; i < 7; i++) sum_ext = sum_ext + EXT_W'(s2_p[i]);
    sum_sat = (|sum_ext[EXT_W-1:SCORE_W]) ? '1 : sum_ext[SCORE_W-1:0];
  end

  // Control state, counters, pipeline valids and result registers
  always_ff @(posedge clk) begin
    if (!reset_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      v4          <= 1'b0;
      best_score  <= '1;
      best_id     <= '0;
      best_index  <= '0;
      match_found <= 1'b0;
    end else begin
      state_q <= state_d;
      v1      <= accept;
      v2      <= v1;
      v3      <= v2;
      v4      <= v3;
      if (start_ok) begin
        cnt_q       <= '0;
        best_score  <= '1;
        best_id     <= '0;
        best_index  <= '0;
        match_found <= 1'b0;
      end else begin
        if (accept) cnt_q <= cnt_q + 1'b1;
        if (v3 && (s3_score < best_score)) begin
          best_score <= s3_score;
          best_id    <= s3_id;
          best_index <= s3_idx;
        end
        if (state_q == DRAIN && state_d == DONE) match_found <= (best_score <= thr_q);
      end
    end
  end

  // Configuration latched on an accepted start
  always_ff @(posedge clk) begin
    if (start_ok) begin
      cur_q   <= cur_feat[FEAT_W-1:ID_W];
      ncand_q <= num_cand;
      wgt_q   <= weights;
      thr_q   <= threshold;
    end
  end

  // Datapath: S1 absolute differences, S2 weighted products, S3 saturated sum
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_d[0] <= DIFF_W'(abs_coord(cand_feat[X_LO +: COORD_W], cur_q[X_LO +: COORD_W]));
      s1_d[1] <= DIFF_W'(abs_coord(cand_feat[Y_LO +: COORD_W], cur_q[Y_LO +: COORD_W]));
      s1_d[2] <= DIFF_W'(abs_coord(cand_feat[W_LO +: COORD_W], cur_q[W_LO +: COORD_W]));
      s1_d[3] <= DIFF_W'(abs_coord(cand_feat[H_LO +: COORD_W], cur_q[H_LO +: COORD_W]));
      s1_d[4] <= DIFF_W'(sad_color(cand_feat[C1_LO +: 3*CH_W], cur_q[C1_LO +: 3*CH_W]));
      s1_d[5] <= DIFF_W'(sad_color(cand_feat[C2_LO +: 3*CH_W], cur_q[C2_LO +: 3*CH_W]));
      s1_d[6] <= DIFF_W'(abs_dh(cand_feat[DH_LO +: DH_W], cur_q[DH_LO +: DH_W]));
      s1_id   <= cand_feat[ID_W-1:0];
      s1_idx  <= cnt_q;
    end
    if (v1) begin
      for (int unsigned i = 0; i < 7; i++)
        s2_p[i] <= PROD_W'(s1_d[i]) * PROD_W'(wgt_q[(6-i)*WGT_W +: WGT_W]);
      s2_id  <= s1_id;
      s2_idx <= s1_idx;
    end
    if (v2) begin
      s3_score <= sum_sat;
      s3_id    <= s2_id;
      s3_idx   <= s2_idx;
    end
  end

endmodule

// File: tb/tb_oflow_similarity_best_match.sv
// Self-checking bench for oflow_similarity_best_match: directed cases plus
// randomized runs scored by an arithmetic reference model.
module tb_oflow_similarity_best_match;

  logic         oflow_clk = 1'b0;
  logic         reset_N, start, cand_valid;
  logic [111:0] cur_feat, cand_feat;
  logic [6:0]   num_cand;
  logic [55:0]  weights;
  logic [31:0]  threshold;
  logic         cand_ready, busy, done, match_found;
  logic [31:0]  best_score;
  logic [11:0]  best_id;
  logic [6:0]   best_index;

  always #5 oflow_clk = ~oflow_clk;

  oflow_similarity_best_match #(
    .COORD_W(11), .CH_W(8), .DH_W(8), .ID_W(12), .WGT_W(8), .SCORE_W(32), .CNT_W(7)
  ) dut (
    .clk(oflow_clk), .reset_N(reset_N), .start(start), .cur_feat(cur_feat),
    .num_cand(num_cand), .weights(weights), .threshold(threshold),
    .cand_valid(cand_valid), .cand_feat(cand_feat), .cand_ready(cand_ready),
    .busy(busy), .done(done), .best_score(best_score), .best_id(best_id),
    .best_index(best_index), .match_found(match_found)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit [111:0]  cands [128];
  logic [31:0] r_score;
  logic [11:0] r_id;
  logic [6:0]  r_idx;
  logic        r_match;

  function automatic bit [111:0] mk(input int x, input int y, input int w, input int h,
                                    input int unsigned c1, input int unsigned c2,
                                    input int dh, input int id);
    return {11'(x), 11'(y), 11'(w), 11'(h), 24'(c1), 24'(c2), 8'(dh), 12'(id)};
  endfunction

  function automatic int unsigned fld(input bit [111:0] f, input int lo, input int w);
    bit [111:0] t;
    t = f >> lo;
    return t[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic int unsigned wt(input bit [55:0] w, input int k);
    bit [55:0] t;
    t = w >> (8 * (6 - k));
    return {24'd0, t[7:0]};
  endfunction

  function automatic int unsigned adiff(input int unsigned a, input int unsigned b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Weighted L1 distance straight from the feature definitions
  function automatic longint unsigned model_score(input bit [111:0] cur, input bit [111:0] cand,
                                                  input bit [55:0] w);
    longint unsigned s;
    int unsigned     d;
    s = 0;
    for (int k = 0; k < 4; k++)
      s += longint'(adiff(fld(cur, 101 - 11*k, 11), fld(cand, 101 - 11*k, 11)) * wt(w, k));
    for (int c = 0; c < 2; c++) begin
      d = 0;
      for (int ch = 0; ch < 3; ch++)
        d += adiff(fld(cur, 44 - 24*c + 8*ch, 8), fld(cand, 44 - 24*c + 8*ch, 8));
      s += longint'(d * wt(w, 4 + c));
    end
    s += longint'(adiff(fld(cur, 12, 8), fld(cand, 12, 8)) * wt(w, 6));
    if (s > 64'hFFFF_FFFF) s = 64'hFFFF_FFFF;
    return s;
  endfunction

  function automatic longint unsigned model_best(input bit [111:0] cur, input int n,
                                                 input bit [55:0] w);
    longint unsigned b, s;
    b = 64'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      s = model_score(cur, cands[i], w);
      if (s < b) b = s;
    end
    return b;
  endfunction

  task automatic run_op(input string tag, input bit [111:0] cur, input int n,
                        input bit [55:0] w, input bit [31:0] thr,
                        input bit gaps, input bit disturb);
    longint unsigned e_score, s;
    int              e_id, e_idx, acc, cyc, lat;
    bit              e_match, got;
    e_score = 64'hFFFF_FFFF; e_id = 0; e_idx = 0;
    for (int i = 0; i < n; i++) begin
      s = model_score(cur, cands[i], w);
      if (s < e_score) begin
        e_score = s; e_id = int'(cands[i][11:0]); e_idx = i;
      end
    end
    e_match = (n != 0) && (e_score <= longint'(thr));

    start = 1'b1; cur_feat = cur; num_cand = 7'(n); weights = w; threshold = thr;
    @(posedge oflow_clk); #1;
    start     = 1'b0;
    cur_feat  = 112'({$urandom, $urandom, $urandom, $urandom});
    num_cand  = 7'($urandom);
    weights   = 56'({$urandom, $urandom});
    threshold = $urandom;
    lat = 0;
    if (n == 0) begin
      check({tag, "_done_next"}, done, 1);
      check({tag, "_rdy_low"}, cand_ready, 0);
    end else begin
      check({tag, "_busy"}, busy, 1);
      acc = 0; cyc = 0;
      while (acc < n && cyc < 2000) begin
        cand_valid = !gaps || (cyc % 2 == 0);
        cand_feat  = cands[acc];
        if (disturb && cyc == 1) start = 1'b1;
        got = cand_valid && cand_ready;
        @(posedge oflow_clk); #1;
        start = 1'b0;
        if (got) acc++;
        cyc++;
      end
      cand_valid = 1'b0;
      cand_feat  = 112'({$urandom, $urandom, $urandom, $urandom});
      check({tag, "_accepted"}, acc, n);
      check({tag, "_rdy_after"}, cand_ready, 0);
      while (!done && lat < 40) begin
        @(posedge oflow_clk); #1;
        lat++;
      end
      check({tag, "_latency"}, lat, 5);
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_score"}, best_score, e_score);
    check({tag, "_id"}, best_id, 64'(e_id));
    check({tag, "_index"}, best_index, 64'(e_idx));
    check({tag, "_match"}, match_found, e_match);
    r_score = best_score; r_id = best_id; r_idx = best_index; r_match = match_found;
    @(posedge oflow_clk); #1;
    check({tag, "_pulse"}, done, 0);
    check({tag, "_hold"}, best_score, e_score);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_score"}, best_score, 32'hFFFF_FFFF);
    check({tag, "_id"}, best_id, 0);
    check({tag, "_index"}, best_index, 0);
    check({tag, "_match"}, match_found, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rdy"}, cand_ready, 0);
  endtask

  localparam bit [55:0] W_ONES = 56'h01_01_01_01_01_01_01;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [111:0]      cur;
    bit [55:0]       w;
    logic [31:0]     s4_score;
    logic [11:0]     s4_id;
    logic [6:0]      s4_idx;
    longint unsigned eb;
    int              n, j;
    bit              seen;

    reset_N = 1'b0; start = 1'b0; cand_valid = 1'b0;
    cur_feat = '0; cand_feat = '0; num_cand = '0; weights = '0; threshold = '0;
    repeat (3) @(posedge oflow_clk);
    #1;
    check_reset_vals("rst");
    reset_N = 1'b1;
    @(posedge oflow_clk); #1;

    // T1: closest in y wins
    cands[0] = mk(12, 20, 5, 5, 0, 0, 0, 7);
    cands[1] = mk(10, 21, 5, 5, 0, 0, 0, 9);
    run_op("t1", mk(10, 20, 5, 5, 0, 0, 0, 0), 2, W_ONES, 100, 0, 0);
    check("t1_score_c", r_score, 1);
    check("t1_id_c", r_id, 9);
    check("t1_index_c", r_idx, 1);

    // T2: tie keeps the first arrival
    cands[0] = mk(13, 20, 5, 5, 0, 0, 0, 4);
    cands[1] = mk(10, 23, 5, 5, 0, 0, 0, 5);
    run_op("t2", mk(10, 20, 5, 5, 0, 0, 0, 0), 2, W_ONES, 2, 0, 0);
    check("t2_score_c", r_score, 3);
    check("t2_id_c", r_id, 4);
    check("t2_index_c", r_idx, 0);

    // T3: no candidates
    run_op("t3", mk(1, 2, 3, 4, 5, 6, 7, 8), 0, W_ONES, 32'hFFFF_FFFF, 0, 0);
    check("t3_score_c", r_score, 32'hFFFF_FFFF);
    check("t3_match_c", r_match, 0);

    // T4: same five candidates back-to-back and with gaps
    cur = mk($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
             $urandom_range(0, 2047), $urandom & 32'hFFFFFF, $urandom & 32'hFFFFFF,
             $urandom_range(0, 255), 0);
    for (int i = 0; i < 5; i++)
      cands[i] = mk($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                    $urandom_range(0, 2047), $urandom & 32'hFFFFFF, $urandom & 32'hFFFFFF,
                    $urandom_range(0, 255), $urandom_range(0, 4095));
    w = 56'({$urandom, $urandom});
    run_op("t4_b2b", cur, 5, w, $urandom, 0, 0);
    s4_score = r_score; s4_id = r_id; s4_idx = r_idx;
    run_op("t4_gap", cur, 5, w, $urandom, 1, 1);
    check("t4_same_score", r_score, s4_score);
    check("t4_same_id", r_id, s4_id);
    check("t4_same_index", r_idx, s4_idx);

    // T5: colour distance and threshold boundary
    cands[0] = mk($urandom_range(0, 2047), 7, 9, 11, 24'h0F2232, $urandom & 32'hFFFFFF, 3, 21);
    cur      = mk(100, 200, 300, 400, 24'h102030, 24'h555555, 77, 0);
    run_op("t5_thr9", cur, 1, 56'h00_00_00_00_02_00_00, 9, 0, 0);
    check("t5_score_c", r_score, 10);
    check("t5_match9_c", r_match, 0);
    run_op("t5_thr10", cur, 1, 56'h00_00_00_00_02_00_00, 10, 0, 0);
    check("t5_match10_c", r_match, 1);

    // T6: reset in the middle of a run
    cands[0] = mk(12, 20, 5, 5, 0, 0, 0, 7);
    cands[1] = mk(10, 21, 5, 5, 0, 0, 0, 9);
    start = 1'b1; cur_feat = mk(10, 20, 5, 5, 0, 0, 0, 0); num_cand = 7'd2;
    weights = W_ONES; threshold = 100;
    @(posedge oflow_clk); #1;
    start = 1'b0; cand_valid = 1'b1; cand_feat = cands[0];
    @(posedge oflow_clk); #1;
    cand_valid = 1'b0;
    check("t6_busy", busy, 1);
    reset_N = 1'b0;
    @(posedge oflow_clk); #1;
    reset_N = 1'b1;
    check_reset_vals("t6_rst");
    seen = 0;
    repeat (10) begin
      @(posedge oflow_clk); #1;
      if (done) seen = 1;
    end
    check("t6_no_done", seen, 0);
    run_op("t6_rerun", mk(10, 20, 5, 5, 0, 0, 0, 0), 2, W_ONES, 100, 0, 0);
    check("t6_score_c", r_score, 1);
    check("t6_id_c", r_id, 9);
    check("t6_index_c", r_idx, 1);

    // Randomized runs with occasional duplicate features to create ties
    for (int it = 0; it < 12; it++) begin
      n   = $urandom_range(1, 12);
      cur = mk($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
               $urandom_range(0, 2047), $urandom & 32'hFFFFFF, $urandom & 32'hFFFFFF,
               $urandom_range(0, 255), $urandom_range(0, 4095));
      for (int i = 0; i < n; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) begin
          j = $urandom_range(0, i - 1);
          cands[i] = {cands[j][111:12], 12'($urandom)};
        end else begin
          cands[i] = mk($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                        $urandom_range(0, 2047), $urandom & 32'hFFFFFF, $urandom & 32'hFFFFFF,
                        $urandom_range(0, 255), $urandom_range(0, 4095));
        end
      end
      w  = 56'({$urandom, $urandom});
      eb = model_best(cur, n, w);
      if (eb == 0) eb = 1;
      run_op($sformatf("rnd%0d", it), cur, n, w, 32'(eb - 1 + $urandom_range(0, 2)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
